cond_gate_unit: RTL and testbench



---
 rtl/cond_gate_unit.sv | 97 +++++++++
 tb/tb_cond_gate_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cond_gate_unit.sv
// cond_gate_unit: holds one conditional instruction until the NZCV flags are current, then issues execute/squash.
// Optional COND_GATE_BYPASS_EN forwards the final in-flight flag write straight into evaluation.
module cond_gate_unit #(
   parameter int MAX_PENDING = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [3:0] cond_field,
   input  logic       set_cond_bit,
   input  logic       flag_wr_valid,
   input  logic [3:0] flag_wr_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_execute,
   output logic       out_set,
   output logic [2:0] pending_count,
   output logic       underflow_err
);
   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
   localparam logic [2:0] MAX_P = 3'(MAX_PENDING);
   state_t state;
   logic [3:0] cond_q, flags, cond_c;
   logic s_q, s_c, needs, room, flags_ok, bypass, can_eval, eval, pass, inc, dec;

   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, r;
      {n, z, cy, v} = f;
      case (c)
         4'd0:    r = z;
         4'd1:    r = !z;
         4'd2:    r = cy;
         4'd3:    r = !cy;
         4'd4:    r = n;
         4'd5:    r = !n;
         4'd6:    r = v;
         4'd7:    r = !v;
         4'd8:    r = cy && !z;
         4'd9:    r = !cy || z;
         4'd10:   r = n == v;
         4'd11:   r = n != v;
         4'd12:   r = !z && (n == v);
         4'd13:   r = z || (n != v);
         4'd14:   r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // In IDLE the instruction is evaluated straight off the input bus in its accept cycle.
   assign cond_c   = (state == IDLE) ? cond_field : cond_q;
   assign s_c      = (state == IDLE) ? set_cond_bit : s_q;
   assign needs    = cond_c[3:1] != 3'b111;
   assign room     = !s_c || pending_count < MAX_P;
   assign flags_ok = !needs || pending_count == 3'd0;
`ifdef COND_GATE_BYPASS_EN
   assign bypass   = state == WAIT && needs && pending_count == 3'd1 && flag_wr_valid;
`else
   assign bypass   = 1'b0;
`endif
   assign can_eval = room && (flags_ok || bypass);
   assign eval     = ((state == IDLE && instr_valid) || state == WAIT) && can_eval;
   assign pass     = cond_pass(cond_c, bypass ? flag_wr_data : flags);
   assign inc      = eval && pass && s_c;
   assign dec      = flag_wr_valid && pending_count != 3'd0;
   assign instr_ready = state == IDLE;
   assign out_valid   = state == HOLD;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         cond_q        <= 4'd0;
         s_q           <= 1'b0;
         flags         <= 4'd0;
         pending_count <= 3'd0;
         underflow_err <= 1'b0;
         out_execute   <= 1'b0;
         out_set       <= 1'b0;
      end else begin
         if (flag_wr_valid) flags <= flag_wr_data;
         if (flag_wr_valid && pending_count == 3'd0) underflow_err <= 1'b1;
         pending_count <= pending_count + {2'b00, inc} - {2'b00, dec};
         if (state == IDLE && instr_valid) begin
            cond_q <= cond_field;
            s_q    <= set_cond_bit;
         end
         if (eval) begin
            out_execute <= pass;
            out_set     <= pass && s_c;
         end
         state <= eval ? HOLD :
                  (state == IDLE && instr_valid) ? WAIT :
                  (state == HOLD && out_ready) ? IDLE : state;
      end
   end
endmodule

// File: tb/tb_cond_gate_unit.sv
// tb_cond_gate_unit: directed scenarios plus random traffic against a transaction-level model of cond_gate_unit.
module tb_cond_gate_unit;
   localparam int MAX = 3;
   logic clk = 0, rst_n = 0;
   logic instr_valid = 0, set_cond_bit = 0, flag_wr_valid = 0, out_ready = 0;
   logic [3:0] cond_field = 0, flag_wr_data = 0;
   logic instr_ready, out_valid, out_execute, out_set, underflow_err;
   logic [2:0] pending_count;
   int errors = 0, checks = 0;
   int m_phase = 0, m_pend = 0;
   bit [3:0] m_cond = 0, m_flags = 0;
   bit m_s = 0, m_exec = 0, m_set = 0, m_err = 0;

   cond_gate_unit #(.MAX_PENDING(MAX)) dut (
      .clock(clk), .reset(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .cond_field(cond_field), .set_cond_bit(set_cond_bit), .flag_wr_valid(flag_wr_valid),
      .flag_wr_data(flag_wr_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_execute(out_execute), .out_set(out_set), .pending_count(pending_count),
      .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   // ARM conditions come in complementary pairs: the low bit inverts the pair's base test.
   function automatic bit arm_cond(bit [3:0] c, bit [3:0] f);
      bit n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = n == v;
         3'd6: base = !z && (n == v);
         default: base = 1;
      endcase
      return base ^ c[0];
   endfunction

   function automatic bit ready_to_eval(bit [3:0] c, bit s, int p);
      return (c[3:1] == 3'b111 || p == 0) && (!s || p < MAX);
   endfunction

   task automatic check(string tag, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      int ph = m_phase;
      bit ev = 0, ps = 0;
      bit [3:0] f = m_flags;
      if (!rst_n) begin
         m_phase = 0; m_pend = 0; m_flags = 0; m_err = 0; m_exec = 0; m_set = 0; m_cond = 0; m_s = 0;
         return;
      end
      if (ph == 0 && instr_valid) begin
         m_cond = cond_field; m_s = set_cond_bit; m_phase = 1;
      end
      if ((ph == 0 && instr_valid) || ph == 1) begin
         if (ready_to_eval(m_cond, m_s, m_pend)) ev = 1;
`ifdef COND_GATE_BYPASS_EN
         else if (ph == 1 && m_cond[3:1] != 3'b111 && m_pend == 1 && flag_wr_valid && (!m_s || m_pend < MAX)) begin
            ev = 1; f = flag_wr_data;
         end
`endif
      end
      if (ev) begin
         ps = arm_cond(m_cond, f);
         m_exec = ps; m_set = ps && m_s; m_phase = 2;
      end else if (ph == 2 && out_ready) m_phase = 0;
      if (flag_wr_valid) begin
         if (m_pend == 0) m_err = 1;
         else m_pend--;
         m_flags = flag_wr_data;
      end
      if (ev && ps && m_s) m_pend++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("instr_ready", instr_ready, int'(m_phase == 0));
      check("out_valid", out_valid, int'(m_phase == 2));
      check("pending_count", pending_count, m_pend);
      check("underflow_err", underflow_err, m_err);
      if (m_phase == 2) begin
         check("out_execute", out_execute, m_exec);
         check("out_set", out_set, m_set);
      end
   endtask

   task automatic issue(bit [3:0] c, bit s);
      instr_valid = 1; cond_field = c; set_cond_bit = s;
      step();
      instr_valid = 0;
   endtask

   initial begin
      step(); step();
      check("rst_ready", instr_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_pend", pending_count, 0);
      rst_n = 1; out_ready = 1;
      issue(4'd14, 1);
      check("al_valid", out_valid, 1);
      check("al_exec", out_execute, 1);
      check("al_set", out_set, 1);
      check("al_pend", pending_count, 1);
      step();
      issue(4'd0, 0);
      step(); step();
      flag_wr_valid = 1; flag_wr_data = 4'b0100;
      step();
      flag_wr_valid = 0;
`ifndef COND_GATE_BYPASS_EN
      check("eq_wait_valid", out_valid, 0);
      step();
`endif
      check("eq_valid", out_valid, 1);
      check("eq_exec", out_execute, 1);
      step();
      flag_wr_valid = 1; flag_wr_data = 4'b1000;
      step();
      flag_wr_valid = 0;
      check("uf_err", underflow_err, 1);
      check("uf_pend", pending_count, 0);
      issue(4'd10, 0);
      check("ge_exec", out_execute, 0);
      step();
      issue(4'd11, 0);
      check("lt_exec", out_execute, 1);
      step();
      issue(4'd15, 0);
      check("nv_valid", out_valid, 1);
      check("nv_exec", out_execute, 0);
      step();
      check("uf_sticky", underflow_err, 1);
      repeat (3) begin
         issue(4'd14, 1);
         step();
      end
      check("max_pend", pending_count, 3);
      issue(4'd14, 1);
      check("stall_ready", instr_ready, 0);
      check("stall_valid", out_valid, 0);
      step(); step();
      check("stall_hold", instr_ready, 0);
      flag_wr_valid = 1;
      step();
      flag_wr_valid = 0;
      step();
      check("rel_valid", out_valid, 1);
      check("rel_pend", pending_count, 3);
      out_ready = 0;
      repeat (5) begin
         step();
         check("hold_valid", out_valid, 1);
         check("hold_exec", out_execute, 1);
         check("hold_set", out_set, 1);
      end
      rst_n = 0;
      step();
      check("abort_valid", out_valid, 0);
      check("abort_pend", pending_count, 0);
      check("abort_err", underflow_err, 0);
      rst_n = 1;
      repeat (3000) begin
         rst_n         = $urandom_range(99) != 0;
         instr_valid   = 1'($urandom_range(1));
         cond_field    = 4'($urandom);
         set_cond_bit  = 1'($urandom);
         flag_wr_valid = $urandom_range(3) == 0;
         flag_wr_data  = 4'($urandom);
         out_ready     = $urandom_range(2) != 0;
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
